// File: rtl/literal_packer.sv
// literal_packer: packs a stream of literal bytes into OUT_BYTES-wide words.
// A word is emitted once OUT_BYTES bytes are gathered, or early on a byte tagged
// last. Each word carries a contiguous byte-keep mask and a last flag.
// Optional build macro: LITERAL_PACKER_STATS_EN adds the stat_bytes/stat_words
// saturating counters.
module literal_packer #(
   parameter int unsigned OUT_BYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   input_valid,
   input  logic [7:0]             input_payload,
   input  logic                   input_last,
   output logic                   input_ready,
   output logic                   output_valid,
   output logic [OUT_BYTES*8-1:0] output_payload,
   output logic [OUT_BYTES-1:0]   output_keep,
   output logic                   output_last,
   input  logic                   output_ready
`ifdef LITERAL_PACKER_STATS_EN
   ,
   output logic [31:0]            stat_bytes,
   output logic [31:0]            stat_words
`endif
);

   localparam int unsigned CNT_W  = $clog2(OUT_BYTES) + 1;
   localparam int unsigned WORD_W = OUT_BYTES * 8;

   logic [WORD_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]     fill_q, fill_d;
   logic                 out_valid_q, out_valid_d;
   logic [WORD_W-1:0]    out_payload_q, out_payload_d;
   logic [OUT_BYTES-1:0] out_keep_q, out_keep_d;
   logic                 out_last_q, out_last_d;

   logic                 accept;
   logic                 out_hs;
   logic                 complete;
   logic [WORD_W-1:0]    merged;
   logic [OUT_BYTES-1:0] keep_mask;

   // The output slot is free when empty or being drained this cycle.
   assign input_ready = ~out_valid_q | output_ready;
   assign accept      = input_valid & input_ready;
   assign out_hs      = out_valid_q & output_ready;
   assign complete    = accept & ((fill_q == CNT_W'(OUT_BYTES - 1)) | input_last);

   assign output_valid   = out_valid_q;
   assign output_payload = out_payload_q;
   assign output_keep    = out_keep_q;
   assign output_last    = out_last_q;

   // Merge the incoming byte at the fill lane, zero lanes above it, build keep.
   always_comb begin
      merged    = acc_q;
      keep_mask = '0;
      for (int i = 0; i < int'(OUT_BYTES); i++) begin
         if (CNT_W'(i) == fill_q) begin
            merged[i*8 +: 8] = input_payload;
         end else if (CNT_W'(i) > fill_q) begin
            merged[i*8 +: 8] = 8'h00;
         end
         keep_mask[i] = (CNT_W'(i) <= fill_q);
      end
   end

   // Next-state for accumulator, fill count and output register.
   always_comb begin
      acc_d         = acc_q;
      fill_d        = fill_q;
      out_valid_d   = out_valid_q;
      out_payload_d = out_payload_q;
      out_keep_d    = out_keep_q;
      out_last_d    = out_last_q;

      if (out_hs) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (complete) begin
            acc_d         = '0;
            fill_d        = '0;
            out_valid_d   = 1'b1;
            out_payload_d = merged;
            out_keep_d    = keep_mask;
            out_last_d    = input_last;
         end else begin
            acc_d  = merged;
            fill_d = fill_q + CNT_W'(1);
         end
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q         <= '0;
         fill_q        <= '0;
         out_valid_q   <= 1'b0;
         out_payload_q <= '0;
         out_keep_q    <= '0;
         out_last_q    <= 1'b0;
      end else begin
         acc_q         <= acc_d;
         fill_q        <= fill_d;
         out_valid_q   <= out_valid_d;
         out_payload_q <= out_payload_d;
         out_keep_q    <= out_keep_d;
         out_last_q    <= out_last_d;
      end
   end

`ifdef LITERAL_PACKER_STATS_EN
   logic [31:0] stat_bytes_q, stat_bytes_d;
   logic [31:0] stat_words_q, stat_words_d;

   assign stat_bytes = stat_bytes_q;
   assign stat_words = stat_words_q;

   // Saturating byte and word counters.
   always_comb begin
      stat_bytes_d = stat_bytes_q;
      stat_words_d = stat_words_q;
      if (accept && (stat_bytes_q != 32'hFFFF_FFFF)) begin
         stat_bytes_d = stat_bytes_q + 32'd1;
      end
      if (out_hs && (stat_words_q != 32'hFFFF_FFFF)) begin
         stat_words_d = stat_words_q + 32'd1;
      end
   end

   // Counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_bytes_q <= '0;
         stat_words_q <= '0;
      end else begin
         stat_bytes_q <= stat_bytes_d;
         stat_words_q <= stat_words_d;
      end
   end
`endif

endmodule
